// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 host command controller.
package ps2_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INHIBIT,
        ST_RTS,
        ST_SEND,
        ST_ACKBIT,
        ST_WAIT_RESP,
        ST_BAT_WAIT
    } state_t;

    localparam logic [7:0] CMD_RESET     = 8'hFF;
    localparam logic [7:0] CMD_SET_LED   = 8'hED;
    localparam logic [7:0] CMD_TYPEMATIC = 8'hF3;

    localparam logic [7:0] RSP_ACK    = 8'hFA;
    localparam logic [7:0] RSP_RESEND = 8'hFE;
    localparam logic [7:0] RSP_BAT_OK = 8'hAA;

    localparam logic [1:0] ERR_NOACK   = 2'd0;
    localparam logic [1:0] ERR_TIMEOUT = 2'd1;
    localparam logic [1:0] ERR_RETRY   = 2'd2;
    localparam logic [1:0] ERR_BADRESP = 2'd3;

    // Transmit frame: stop bit, odd parity, data byte (shifted LSB first).
    function automatic logic [9:0] build_frame(input logic [7:0] b);
        return {1'b1, ~^b, b};
    endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchroniser for the PS/2 pins plus a registered falling-edge detect on the clock.
// The synced data is delayed to line up with the fall strobe.
module ps2_line_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic clk_in,
    input  logic data_in,
    output logic clk_fall,
    output logic data_s
);

    logic [1:0] clk_ff;
    logic [1:0] data_ff;
    logic       clk_prev;

    // Idle bus level is high, so flops reset to 1 to avoid a spurious fall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_ff   <= 2'b11;
            data_ff  <= 2'b11;
            clk_prev <= 1'b1;
            clk_fall <= 1'b0;
            data_s   <= 1'b1;
        end else begin
            clk_ff   <= {clk_ff[0], clk_in};
            data_ff  <= {data_ff[0], data_in};
            clk_prev <= clk_ff[1];
            clk_fall <= clk_prev & ~clk_ff[1];
            data_s   <= data_ff[1];
        end
    end

endmodule

// File: rtl/ps2_host_cmd_ctrl.sv
// PS/2 host-to-device command sequencer: inhibit, request-to-send, shift frame,
// check line ACK, then wait for the keyboard reply with resend/watchdog handling.
// Optional build macro PS2_HOST_AUTOINIT_EN: self-issue a reset command after
// reset deassertion and wait for the BAT result before accepting commands.
module ps2_host_cmd_ctrl
    import ps2_pkg::*;
#(
    parameter int unsigned INHIBIT_CYC = 2500,
    parameter int unsigned RTS_CYC     = 50,
    parameter int unsigned TIMEOUT_CYC = 375000,
    parameter int unsigned MAX_RETRY   = 3
) (
    input  logic       clk_25MHz,
    input  logic       rst_n,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    input  logic       cmd_valid,
    input  logic [7:0] cmd_byte,
    output logic       cmd_ready,
    input  logic       rx_valid,
    input  logic [7:0] rx_byte,
    output logic       rx_block,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [1:0] err_code
);

    localparam int unsigned CNT_MAX = (INHIBIT_CYC > RTS_CYC) ? INHIBIT_CYC : RTS_CYC;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam int unsigned WD_W    = $clog2(TIMEOUT_CYC + 1);
    localparam int unsigned RT_W    = $clog2(MAX_RETRY + 2);

`ifdef PS2_HOST_AUTOINIT_EN
    localparam logic INIT_RST = 1'b1;
`else
    localparam logic INIT_RST = 1'b0;
`endif

    state_t            state, state_nx;
    logic [CNT_W-1:0]  cnt, cnt_nx;
    logic [WD_W-1:0]   wdog, wdog_nx;
    logic [3:0]        bitn, bitn_nx;
    logic [9:0]        frame, frame_nx;
    logic [RT_W-1:0]   retries, retries_nx;
    logic              init_pend, init_pend_nx;
    logic              data_oe_nx, done_nx, err_nx, wd_active;
    logic [1:0]        err_code_nx;
    logic              clk_fall, data_s;

    ps2_line_sync u_sync (
        .clk      (clk_25MHz),
        .rst_n    (rst_n),
        .clk_in   (ps2_clk_in),
        .data_in  (ps2_data_in),
        .clk_fall (clk_fall),
        .data_s   (data_s)
    );

    // State, datapath and registered outputs; reset releases both lines immediately.
    always_ff @(posedge clk_25MHz or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            wdog        <= '0;
            bitn        <= '0;
            frame       <= '0;
            retries     <= '0;
            init_pend   <= INIT_RST;
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
            cmd_ready   <= ~INIT_RST;
            rx_block    <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
            err_code    <= ERR_NOACK;
        end else begin
            state       <= state_nx;
            cnt         <= cnt_nx;
            wdog        <= wdog_nx;
            bitn        <= bitn_nx;
            frame       <= frame_nx;
            retries     <= retries_nx;
            init_pend   <= init_pend_nx;
            ps2_clk_oe  <= (state_nx == ST_INHIBIT) || (state_nx == ST_RTS);
            ps2_data_oe <= data_oe_nx;
            cmd_ready   <= (state_nx == ST_IDLE) && !init_pend_nx;
            rx_block    <= (state_nx == ST_INHIBIT) || (state_nx == ST_RTS) ||
                           (state_nx == ST_SEND)    || (state_nx == ST_ACKBIT);
            busy        <= (state_nx != ST_IDLE);
            done        <= done_nx;
            err         <= err_nx;
            err_code    <= err_code_nx;
        end
    end

    // Next-state, frame shifting, counters and result generation.
    always_comb begin
        state_nx     = state;
        cnt_nx       = cnt;
        wdog_nx      = wdog;
        bitn_nx      = bitn;
        frame_nx     = frame;
        retries_nx   = retries;
        init_pend_nx = init_pend;
        data_oe_nx   = ps2_data_oe;
        done_nx      = 1'b0;
        err_nx       = 1'b0;
        err_code_nx  = err_code;
        wd_active    = (state == ST_SEND) || (state == ST_ACKBIT) ||
                       (state == ST_WAIT_RESP) || (state == ST_BAT_WAIT);

        if (wd_active) begin
            wdog_nx = wdog + WD_W'(1);
        end

        unique case (state)
            ST_IDLE: begin
                data_oe_nx = 1'b0;
                if (init_pend) begin
                    frame_nx = build_frame(CMD_RESET);
                    cnt_nx   = '0;
                    state_nx = ST_INHIBIT;
                end else if (cmd_valid) begin
                    frame_nx = build_frame(cmd_byte);
                    cnt_nx   = '0;
                    state_nx = ST_INHIBIT;
                end
            end
            ST_INHIBIT: begin
                if (cnt == CNT_W'(INHIBIT_CYC - 1)) begin
                    cnt_nx     = '0;
                    data_oe_nx = 1'b1;
                    state_nx   = ST_RTS;
                end else begin
                    cnt_nx = cnt + CNT_W'(1);
                end
            end
            ST_RTS: begin
                data_oe_nx = 1'b1;
                if (cnt == CNT_W'(RTS_CYC - 1)) begin
                    bitn_nx  = '0;
                    wdog_nx  = '0;
                    state_nx = ST_SEND;
                end else begin
                    cnt_nx = cnt + CNT_W'(1);
                end
            end
            ST_SEND: begin
                if (clk_fall) begin
                    if (bitn == 4'd9) begin
                        data_oe_nx = 1'b0;
                        state_nx   = ST_ACKBIT;
                    end else begin
                        data_oe_nx = ~frame[bitn];
                        bitn_nx    = bitn + 4'd1;
                    end
                end
            end
            ST_ACKBIT: begin
                if (clk_fall) begin
                    if (!data_s) begin
                        state_nx = ST_WAIT_RESP;
                    end else begin
                        err_nx      = 1'b1;
                        err_code_nx = ERR_NOACK;
                    end
                end
            end
            ST_WAIT_RESP: begin
                if (rx_valid) begin
                    if (rx_byte == RSP_ACK) begin
                        if (init_pend) begin
                            wdog_nx  = '0;
                            state_nx = ST_BAT_WAIT;
                        end else begin
                            done_nx = 1'b1;
                        end
                    end else if (rx_byte == RSP_RESEND) begin
                        if (retries < RT_W'(MAX_RETRY)) begin
                            retries_nx = retries + RT_W'(1);
                            cnt_nx     = '0;
                            state_nx   = ST_INHIBIT;
                        end else begin
                            err_nx      = 1'b1;
                            err_code_nx = ERR_RETRY;
                        end
                    end else begin
                        err_nx      = 1'b1;
                        err_code_nx = ERR_BADRESP;
                    end
                end
            end
            ST_BAT_WAIT: begin
                if (rx_valid) begin
                    if (rx_byte == RSP_BAT_OK) begin
                        done_nx = 1'b1;
                    end else begin
                        err_nx      = 1'b1;
                        err_code_nx = ERR_BADRESP;
                    end
                end
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase

        // Watchdog expiry overrides whatever the state logic decided this cycle.
        if (wd_active && (wdog == WD_W'(TIMEOUT_CYC - 1))) begin
            done_nx     = 1'b0;
            err_nx      = 1'b1;
            err_code_nx = ERR_TIMEOUT;
        end

        // Any completion releases the bus and returns to idle in the same cycle.
        if (done_nx || err_nx) begin
            state_nx     = ST_IDLE;
            data_oe_nx   = 1'b0;
            retries_nx   = '0;
            init_pend_nx = 1'b0;
        end
    end

endmodule

// File: tb/tb_ps2_host_cmd_ctrl.sv
// Scoreboard bench for ps2_host_cmd_ctrl with an open-drain PS/2 keyboard model.
module tb_ps2_host_cmd_ctrl;
    import ps2_pkg::*;

    localparam int unsigned INH  = 40;
    localparam int unsigned RTS  = 6;
    localparam int unsigned TMO  = 3000;
    localparam int unsigned MAXR = 3;
    localparam int          HALF = 20;
`ifdef PS2_HOST_AUTOINIT_EN
    localparam logic RST_READY = 1'b0;
`else
    localparam logic RST_READY = 1'b1;
`endif

    typedef struct packed { logic is_err; logic [1:0] code; } res_t;
    typedef struct packed { logic [7:0] b; logic p; } frm_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ps2_clk_in, ps2_data_in, ps2_clk_oe, ps2_data_oe;
    logic       cmd_valid, cmd_ready, rx_valid, rx_block, busy, done, err;
    logic [7:0] cmd_byte, rx_byte;
    logic [1:0] err_code;
    logic       dev_clk_low, dev_data_low;

    res_t res_q[$];
    frm_t frm_q[$];
    res_t mon_e;
    frm_t vec [4];
    int   n_checks = 0;
    int   n_fail = 0;
    int   inh_run = 0;
    int   last_inh = 0;

    always #5 clk = ~clk;

    // Wired-AND bus: either side pulling low wins.
    assign ps2_clk_in  = ~(ps2_clk_oe | dev_clk_low);
    assign ps2_data_in = ~(ps2_data_oe | dev_data_low);

    ps2_host_cmd_ctrl #(
        .INHIBIT_CYC (INH),
        .RTS_CYC     (RTS),
        .TIMEOUT_CYC (TMO),
        .MAX_RETRY   (MAXR)
    ) dut (
        .clk_25MHz   (clk),
        .rst_n       (rst_n),
        .ps2_clk_in  (ps2_clk_in),
        .ps2_data_in (ps2_data_in),
        .ps2_clk_oe  (ps2_clk_oe),
        .ps2_data_oe (ps2_data_oe),
        .cmd_valid   (cmd_valid),
        .cmd_byte    (cmd_byte),
        .cmd_ready   (cmd_ready),
        .rx_valid    (rx_valid),
        .rx_byte     (rx_byte),
        .rx_block    (rx_block),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .err_code    (err_code)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Result monitor: every done/err pulse is matched against the scoreboard queue.
    always @(negedge clk) begin
        if (rst_n && (done || err)) begin
            check("done_err_exclusive", 32'(done & err), 32'd0);
            check("lines_released", 32'({ps2_clk_oe, ps2_data_oe}), 32'd0);
            if (res_q.size() == 0) begin
                check("spurious_result", 32'({done, err}), 32'd0);
            end else begin
                mon_e = res_q.pop_front();
                check("result_is_err", 32'(err), 32'(mon_e.is_err));
                if (err) check("err_code", 32'(err_code), 32'(mon_e.code));
            end
        end
    end

    // Length of the most recent host clock-low (inhibit + request-to-send) interval.
    always @(negedge clk) begin
        if (ps2_clk_oe) begin
            inh_run++;
        end else begin
            if (inh_run != 0) last_inh = inh_run;
            inh_run = 0;
        end
    end

    task automatic send_cmd(input logic [7:0] b);
        int t = 0;
        while (!cmd_ready && t < 5000) begin
            tick(1);
            t++;
        end
        check("cmd_ready_before_issue", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1;
        cmd_byte  = b;
        tick(1);
        cmd_valid = 1'b0;
    endtask

    task automatic reply(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_byte  = b;
        tick(1);
        rx_valid = 1'b0;
    endtask

    task automatic wait_rts();
        int t = 0;
        while (!(ps2_data_oe && !ps2_clk_oe) && t < 3000) begin
            tick(1);
            t++;
        end
        check("rts_seen", 32'(ps2_data_oe & ~ps2_clk_oe), 32'd1);
    endtask

    task automatic wait_idle();
        int t = 0;
        while (busy && t < 2 * TMO) begin
            tick(1);
            t++;
        end
        check("reach_idle", 32'(busy), 32'd0);
        tick(2);
    endtask

    // Keyboard model: clocks 10 bits in (sampled on rising edges), then the ACK clock.
    task automatic device_frame(input logic ack);
        logic [9:0] got;
        frm_t       e;
        got = '0;
        e   = '0;
        wait_rts();
        check("start_bit_low", 32'(ps2_data_in), 32'd0);
        tick(10);
        for (int k = 0; k < 10; k++) begin
            dev_clk_low = 1'b1;
            tick(HALF);
            dev_clk_low = 1'b0;
            got[k] = ps2_data_in;
            tick(HALF);
        end
        check("rx_block_during_send", 32'(rx_block), 32'd1);
        dev_data_low = ack;
        tick(4);
        dev_clk_low = 1'b1;
        tick(HALF);
        dev_clk_low = 1'b0;
        tick(4);
        dev_data_low = 1'b0;
        tick(HALF);
        check("frame_expected", 32'(frm_q.size() != 0), 32'd1);
        if (frm_q.size() != 0) e = frm_q.pop_front();
        check("frame_byte", 32'(got[7:0]), 32'(e.b));
        check("frame_parity", 32'(got[8]), 32'(e.p));
        check("stop_bit", 32'(got[9]), 32'd1);
    endtask

    task automatic run_autoinit();
`ifdef PS2_HOST_AUTOINIT_EN
        frm_q.push_back(frm_t'{b: 8'hFF, p: 1'b1});
        res_q.push_back(res_t'{is_err: 1'b0, code: 2'd0});
        device_frame(1'b1);
        tick(5);
        reply(RSP_ACK);
        tick(5);
        check("autoinit_ready_held", 32'(cmd_ready), 32'd0);
        check("autoinit_busy_bat", 32'(busy), 32'd1);
        reply(RSP_BAT_OK);
        wait_idle();
        check("autoinit_ready_after", 32'(cmd_ready), 32'd1);
`endif
    endtask

    initial begin
        #5_000_000;
        $display("FAIL global_timeout: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

    initial begin
        int t;
        int cnt;
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_byte = '0; rx_valid = 1'b0; rx_byte = '0;
        dev_clk_low = 1'b0; dev_data_low = 1'b0;
        vec[0] = frm_t'{b: 8'hED, p: 1'b1};
        vec[1] = frm_t'{b: 8'h00, p: 1'b1};
        vec[2] = frm_t'{b: 8'h01, p: 1'b0};
        vec[3] = frm_t'{b: 8'hF3, p: 1'b1};
        tick(3);
        check("rst_cmd_ready", 32'(cmd_ready), 32'(RST_READY));
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_clk_oe", 32'(ps2_clk_oe), 32'd0);
        check("rst_data_oe", 32'(ps2_data_oe), 32'd0);
        check("rst_done_err", 32'({done, err}), 32'd0);
        check("rst_rx_block", 32'(rx_block), 32'd0);
        check("rst_err_code", 32'(err_code), 32'd0);
        rst_n = 1'b1;
        run_autoinit();

        // Normal commands acknowledged with 0xFA; parity and inhibit length checked.
        for (int i = 0; i < 4; i++) begin
            frm_q.push_back(vec[i]);
            res_q.push_back(res_t'{is_err: 1'b0, code: 2'd0});
            send_cmd(vec[i].b);
            if (i == 0) begin
                cmd_valid = 1'b1;
                cmd_byte  = 8'h55;
                tick(1);
                cmd_valid = 1'b0;
            end
            device_frame(1'b1);
            check("inhibit_len", 32'(last_inh), 32'(INH + RTS));
            tick(5);
            check("rx_block_wait_resp", 32'(rx_block), 32'd0);
            check("busy_wait_resp", 32'(busy), 32'd1);
            reply(RSP_ACK);
            wait_idle();
        end

        // Stray reply while idle and the ignored busy-time command must start nothing.
        reply(RSP_ACK);
        tick(100);
        check("idle_stays_idle", 32'({busy, ps2_clk_oe}), 32'd0);

        // Missing line ACK.
        frm_q.push_back(frm_t'{b: 8'hA5, p: 1'b1});
        res_q.push_back(res_t'{is_err: 1'b1, code: ERR_NOACK});
        send_cmd(8'hA5);
        device_frame(1'b0);
        wait_idle();

        // Four resend replies: original plus three resends of the same byte, then RETRY.
        for (int i = 0; i < 4; i++) frm_q.push_back(frm_t'{b: 8'hED, p: 1'b1});
        res_q.push_back(res_t'{is_err: 1'b1, code: ERR_RETRY});
        send_cmd(8'hED);
        for (int i = 0; i < 4; i++) begin
            device_frame(1'b1);
            tick(5);
            reply(RSP_RESEND);
        end
        wait_idle();

        // Device never clocks: timeout exactly TMO cycles after clock release.
        res_q.push_back(res_t'{is_err: 1'b1, code: ERR_TIMEOUT});
        send_cmd(8'h07);
        t = 0;
        while (!ps2_clk_oe && t < 500) begin tick(1); t++; end
        while (ps2_clk_oe && t < 1000) begin tick(1); t++; end
        cnt = 0;
        while (!err && cnt < int'(TMO) + 20) begin tick(1); cnt++; end
        check("timeout_cycles", 32'(cnt), 32'(TMO));
        wait_idle();

        // Reset in the middle of a frame releases the lines asynchronously.
        send_cmd(8'hED);
        wait_rts();
        tick(10);
        for (int k = 0; k < 2; k++) begin
            dev_clk_low = 1'b1;
            tick(HALF);
            dev_clk_low = 1'b0;
            tick(HALF);
        end
        check("data_oe_mid_frame", 32'(ps2_data_oe), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_oe", 32'({ps2_clk_oe, ps2_data_oe}), 32'd0);
        check("async_rst_cmd_ready", 32'(cmd_ready), 32'(RST_READY));
        check("async_rst_busy", 32'(busy), 32'd0);
        tick(2);
        rst_n = 1'b1;
        run_autoinit();

        // Recovery: a fresh command after the reset completes normally.
        frm_q.push_back(frm_t'{b: 8'h07, p: 1'b0});
        res_q.push_back(res_t'{is_err: 1'b0, code: 2'd0});
        send_cmd(8'h07);
        device_frame(1'b1);
        tick(5);
        reply(RSP_ACK);
        wait_idle();

        check("results_pending", 32'(res_q.size()), 32'd0);
        check("frames_pending", 32'(frm_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
